// File: rtl/pagerank_iter_ctrl_if.sv
// Handshake bundle between the PageRank top level and the iteration/barrier controller.
// The master side drives run requests and ant reports; the slave side is the controller.
interface pagerank_iter_ctrl_if #(
  parameter int NUM_ANTS = 4,
  parameter int ITER_W   = 13,
  parameter int DELTA_W  = 32
);
  logic                        start;
  logic [ITER_W-1:0]           max_iter;
  logic [DELTA_W-1:0]          conv_thresh;
  logic [NUM_ANTS-1:0]         ant_done;
  logic [NUM_ANTS*DELTA_W-1:0] ant_delta;
  logic                        iter_go;
  logic                        run_en;
  logic [ITER_W-1:0]           iter_cnt;
  logic                        busy;
  logic                        converged;
  logic                        timed_out;
  logic                        sort_start;
  logic                        done;

  modport master (
    output start, max_iter, conv_thresh, ant_done, ant_delta,
    input  iter_go, run_en, iter_cnt, busy, converged, timed_out, sort_start, done
  );

  modport slave (
    input  start, max_iter, conv_thresh, ant_done, ant_delta,
    output iter_go, run_en, iter_cnt, busy, converged, timed_out, sort_start, done
  );
endinterface

// File: rtl/pagerank_iter_ctrl.sv
// Iteration/barrier controller: launches each PageRank iteration, gathers per-ant completion
// and rank deltas, and ends the run on convergence, iteration cap or watchdog timeout.
module pagerank_iter_ctrl #(
  parameter int NUM_ANTS   = 4,
  parameter int ITER_W     = 13,
  parameter int DELTA_W    = 32,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  pagerank_iter_ctrl_if.slave bus
);

  localparam int ACC_W = DELTA_W + ((NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_EVAL, S_SORT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ITER_W-1:0]    max_iter_q, max_iter_d;
  logic [DELTA_W-1:0]   conv_thresh_q, conv_thresh_d;
  logic [ITER_W-1:0]    iter_cnt_q, iter_cnt_d;
  logic                 converged_q, converged_d;
  logic                 timed_out_q, timed_out_d;
  logic [NUM_ANTS-1:0]  mask_q, mask_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;

  logic [NUM_ANTS-1:0]  arrivals;
  logic [ACC_W-1:0]     arr_sum;
  logic [ITER_W-1:0]    iter_nx;

  // Only first-time arrivals contribute; a repeat pulse from a finished ant is dropped.
  always_comb begin
    arrivals = bus.ant_done & ~mask_q;
    arr_sum  = '0;
    for (int i = 0; i < NUM_ANTS; i++) begin
      if (arrivals[i]) begin
        arr_sum = arr_sum + ACC_W'(bus.ant_delta[i*DELTA_W +: DELTA_W]);
      end
    end
  end

  assign iter_nx = (&iter_cnt_q) ? iter_cnt_q : iter_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    state_d       = state_q;
    max_iter_d    = max_iter_q;
    conv_thresh_d = conv_thresh_q;
    iter_cnt_d    = iter_cnt_q;
    converged_d   = converged_q;
    timed_out_d   = timed_out_q;
    mask_d        = mask_q;
    acc_d         = acc_q;
    wdog_d        = wdog_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          max_iter_d    = bus.max_iter;
          conv_thresh_d = bus.conv_thresh;
          iter_cnt_d    = '0;
          converged_d   = 1'b0;
          timed_out_d   = 1'b0;
          state_d       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        mask_d  = '0;
        acc_d   = '0;
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        mask_d = mask_q | arrivals;
        acc_d  = acc_q + arr_sum;
        // Completion is tested before the watchdog so a last-cycle arrival still counts.
        if (&mask_d) begin
          state_d = S_EVAL;
        end else if (wdog_q == WDOG_LAST) begin
          timed_out_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_EVAL: begin
        iter_cnt_d = iter_nx;
        if (acc_q < ACC_W'(conv_thresh_q)) begin
          converged_d = 1'b1;
          state_d     = S_SORT;
        end else if (max_iter_q != '0 && iter_nx == max_iter_q) begin
          state_d = S_SORT;
        end else if (max_iter_q == '0 && (&iter_nx)) begin
          state_d = S_SORT;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_SORT:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      max_iter_q    <= '0;
      conv_thresh_q <= '0;
      iter_cnt_q    <= '0;
      converged_q   <= 1'b0;
      timed_out_q   <= 1'b0;
      mask_q        <= '0;
      acc_q         <= '0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      max_iter_q    <= max_iter_d;
      conv_thresh_q <= conv_thresh_d;
      iter_cnt_q    <= iter_cnt_d;
      converged_q   <= converged_d;
      timed_out_q   <= timed_out_d;
      mask_q        <= mask_d;
      acc_q         <= acc_d;
      wdog_q        <= wdog_d;
    end
  end

  assign bus.iter_go    = (state_q == S_LAUNCH);
  assign bus.run_en     = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_EVAL);
  assign bus.busy       = bus.run_en || (state_q == S_SORT);
  assign bus.sort_start = (state_q == S_SORT);
  assign bus.done       = (state_q == S_DONE);
  assign bus.iter_cnt   = iter_cnt_q;
  assign bus.converged  = converged_q;
  assign bus.timed_out  = timed_out_q;

endmodule

// File: doc/pagerank_iter_ctrl.md
Name: pagerank_iter_ctrl

Overview:
Parametrised iteration/barrier controller for the PageRank engine; replaces the fixed 4-ant, fixed-40-update sync logic in the top level. It launches each PageRank iteration across NUM_ANTS ants, collects per-ant completion and per-ant rank-delta reports, and decides whether to run another iteration, stop on convergence, stop on the iteration cap, or abort on a watchdog timeout. On a normal finish it drops run_en to freeze the ants and NoC, then pulses sort_start to the top-10 sorter.

Parameters:
NUM_ANTS, 4, number of ant channels (>=1)
ITER_W, 13, width of iteration counter and max_iter
DELTA_W, 32, width of each ant's delta report and of conv_thresh
WDOG_W, 16, width of per-iteration watchdog counter
WDOG_LIMIT, 4096, cycles allowed in WAIT per iteration before timeout (>=1, < 2^WDOG_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle run request; honoured only in IDLE or DONE
max_iter  in  ITER_W  iteration cap; 0 = no cap; sampled when start is accepted
conv_thresh  in  DELTA_W  convergence threshold; sampled when start is accepted
ant_done  in  NUM_ANTS  per-ant one-cycle pulse: ant finished the current iteration
ant_delta  in  NUM_ANTS*DELTA_W  per-ant unsigned delta; slice i is valid only while ant_done[i]=1
iter_go  out  1  one-cycle pulse: all ants begin the next iteration
run_en  out  1  enable to ants and NoC; replaces clock gating
iter_cnt  out  ITER_W  number of completed iterations
busy  out  1  high in LAUNCH, WAIT, EVAL and SORT
converged  out  1  sticky: run ended on the threshold test
timed_out  out  1  sticky: run ended on the watchdog
sort_start  out  1  one-cycle pulse to the sorter
done  out  1  high in DONE

Behaviour:
- Reset values: all outputs 0. State = IDLE. Internal mask, accumulator and watchdog are cleared.
- Reset asserted mid-run: state returns to IDLE immediately. No sort_start is issued.
- States are IDLE, LAUNCH, WAIT, EVAL, SORT, DONE. All outputs are registered or decoded from state only.
- IDLE: when start=1, latch max_iter and conv_thresh, clear iter_cnt, converged and timed_out, then go to LAUNCH.
- LAUNCH (1 cycle): iter_go=1. Clear the arrival mask, the accumulator and the watchdog. Go to WAIT.
- WAIT:
  - Each cycle, new = ant_done & ~mask. Set mask |= new.
  - acc += sum of ant_delta slices where new[i]=1. Multiple arrivals in one cycle are summed together.
  - A duplicate pulse from an ant whose mask bit is already set is ignored, including its delta.
  - acc width is DELTA_W+clog2(NUM_ANTS) (minimum DELTA_W+1), so it cannot overflow.
  - When mask|new is all ones, go to EVAL on the next cycle.
  - Otherwise the watchdog increments. If watchdog == WDOG_LIMIT-1 and the set is still incomplete, set timed_out=1 and go to DONE. No sort_start is issued in this case.
  - Completion takes priority over timeout when both occur in the same cycle.
- EVAL (1 cycle): iter_cnt += 1. Then, in priority order:
  - if acc < zero-extended conv_thresh: converged=1, go to SORT;
  - else if max_iter != 0 and the new iter_cnt == max_iter: go to SORT;
  - else: go to LAUNCH.
  - iter_cnt saturates at all-ones. Reaching saturation with max_iter=0 also goes to SORT.
- SORT (1 cycle): sort_start=1. Go to DONE.
- DONE: done=1 and results are held. A start here restarts exactly as from IDLE. ant_done is ignored outside WAIT.
- run_en = 1 in LAUNCH, WAIT and EVAL; 0 elsewhere.
- start is ignored while busy=1.
- Latency:
  - start sampled at edge k gives iter_go in the cycle after k.
  - Last ant_done sampled at edge t gives EVAL in cycle t+1, then iter_go or sort_start in cycle t+2.
  - Minimum iteration period is 3 cycles (LAUNCH, WAIT, EVAL).

Test Plan:
- NUM_ANTS=4, max_iter=3, conv_thresh=0, ants report done 5 cycles after each iter_go with delta 100 -> exactly 3 iter_go pulses; iter_cnt=3; one sort_start; converged=0; done=1; run_en=0.
- conv_thresh=50, per-ant deltas 40,40,40,40 in iteration 1 and 10,10,10,10 in iteration 2 (acc 160, then 40) -> stops after 2 iterations with converged=1 and iter_cnt=2.
- In one iteration, ants 0 and 2 pulse in the same cycle (deltas 7 and 9), ant 0 pulses again with delta 1000, then ants 1 and 3 (deltas 5 and 5) -> acc=26; the duplicate is ignored; exactly one EVAL.
- WDOG_LIMIT=16 and ant 3 never reports -> timed_out=1 and done=1 exactly 16 cycles into WAIT; no sort_start; iter_cnt unchanged.
- reset asserted during WAIT of iteration 2 -> all outputs 0 at once; a following start runs cleanly from iter_cnt=0.
- start issued in DONE with max_iter=1 -> converged and timed_out cleared; a single iteration runs; sort_start pulses again; start pulsed during WAIT is ignored.
